// File: rtl/gl_pa_pkg.sv
// ----------------------------------------------------------------------------
// gl_pa_pkg
// Shared definitions for the primitive-assembly stage:
//   - pa_mode_e  : assembly mode encodings (list / strip / fan / reserved)
//   - pa_state_e : assembler FSM state encoding
//   - FLUSH_WORD : all-ones flush marker of a given vertex width
// ----------------------------------------------------------------------------
package gl_pa_pkg;

  // Widest vertex word the marker helper can describe.
  localparam int unsigned PA_MAX_W = 1024;

  typedef enum logic [1:0] {
    PA_LIST  = 2'd0,
    PA_STRIP = 2'd1,
    PA_FAN   = 2'd2,
    PA_RSVD  = 2'd3
  } pa_mode_e;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    EMIT  = 2'd3
  } pa_state_e;

  // Low w bits set: the flush marker for a w-bit vertex word.
  function automatic logic [PA_MAX_W-1:0] FLUSH_WORD(input int unsigned w);
    FLUSH_WORD = ~({PA_MAX_W{1'b1}} << w);
  endfunction

endpackage

// File: rtl/gl_prim_assembler.sv
// ----------------------------------------------------------------------------
// gl_prim_assembler
// Pops vertex/color pairs from first-word-fall-through FIFOs and assembles
// them into triangles (list, strip or fan), presenting each triangle to the
// rasterizer over a valid/ready handshake. An all-ones vertex word is a flush
// marker: it is consumed, never stored, pulses flush_out and discards any
// partial primitive.
//
// Build option:
//   GL_PA_STRIP_WINDING_EN - in strip mode, odd-parity triangles are emitted
//                            as (S1,S0,S2) to keep a consistent winding.
//
// Ports:
//   clk        raster clock
//   reset      asynchronous, active-low reset
//   mode       0 list, 1 strip, 2 fan, 3 reserved (treated as list)
//   in_empty   source FIFOs empty
//   in_vertex  FWFT vertex word (x,y,z MSB-first)
//   in_color   FWFT color word (r,g,b MSB-first)
//   in_rd_en   pop both FIFOs this cycle
//   out_valid  triangle present on out_v*/out_c*
//   out_ready  rasterizer accepts triangle
//   out_v0..2  triangle vertices in emission order
//   out_c0..2  matching colors
//   flush_out  one-cycle pulse when a flush marker is consumed
//   busy       low only when idle in FILL0 with no triangle pending
//   tri_count  triangles emitted since reset (wraps)
// ----------------------------------------------------------------------------
module gl_prim_assembler
  import gl_pa_pkg::*;
#(
  parameter int VTX_W = 96,
  parameter int COL_W = 96,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             in_empty,
  input  logic [VTX_W-1:0] in_vertex,
  input  logic [COL_W-1:0] in_color,
  output logic             in_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VTX_W-1:0] out_v0,
  output logic [VTX_W-1:0] out_v1,
  output logic [VTX_W-1:0] out_v2,
  output logic [COL_W-1:0] out_c0,
  output logic [COL_W-1:0] out_c1,
  output logic [COL_W-1:0] out_c2,
  output logic             flush_out,
  output logic             busy,
  output logic [CNT_W-1:0] tri_count
);

  localparam logic [PA_MAX_W-1:0] FLUSH_FULL = FLUSH_WORD(VTX_W);
  localparam logic [VTX_W-1:0]    FLUSH      = FLUSH_FULL[VTX_W-1:0];

  pa_state_e        state;
  pa_mode_e         mode_q;
  logic             parity;
  logic             run_q;
  logic [VTX_W-1:0] s_v0, s_v1, s_v2;
  logic [COL_W-1:0] s_c0, s_c1, s_c2;
  logic             is_flush;
  logic             swap;

  // run_q holds off popping until the first clock edge after reset release,
  // so a late-released reset can never race the first FIFO read.
  assign in_rd_en  = run_q && !in_empty && (state != EMIT);
  assign is_flush  = (in_vertex == FLUSH);
  assign out_valid = (state == EMIT);
  assign busy      = (state != FILL0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL0;
      mode_q    <= PA_LIST;
      parity    <= 1'b0;
      run_q     <= 1'b0;
      flush_out <= 1'b0;
      tri_count <= '0;
      s_v0      <= '0;
      s_v1      <= '0;
      s_v2      <= '0;
      s_c0      <= '0;
      s_c1      <= '0;
      s_c2      <= '0;
    end else begin
      run_q     <= 1'b1;
      flush_out <= 1'b0;
      if (in_rd_en && is_flush) begin
        // Marker: drop any partial primitive and restart from FILL0.
        flush_out <= 1'b1;
        parity    <= 1'b0;
        state     <= FILL0;
      end else begin
        case (state)
          FILL0: if (in_rd_en) begin
            s_v0   <= in_vertex;
            s_c0   <= in_color;
            // Mode is sampled once per primitive; reserved behaves as list.
            mode_q <= (pa_mode_e'(mode) == PA_RSVD) ? PA_LIST : pa_mode_e'(mode);
            state  <= FILL1;
          end
          FILL1: if (in_rd_en) begin
            s_v1  <= in_vertex;
            s_c1  <= in_color;
            state <= FILL2;
          end
          FILL2: if (in_rd_en) begin
            s_v2  <= in_vertex;
            s_c2  <= in_color;
            state <= EMIT;
          end
          EMIT: if (out_ready) begin
            tri_count <= tri_count + CNT_W'(1);
            case (mode_q)
              PA_STRIP: begin
                s_v0   <= s_v1;
                s_c0   <= s_c1;
                s_v1   <= s_v2;
                s_c1   <= s_c2;
                parity <= ~parity;
                state  <= FILL2;
              end
              PA_FAN: begin
                s_v1  <= s_v2;
                s_c1  <= s_c2;
                state <= FILL2;
              end
              default: state <= FILL0;
            endcase
          end
          default: state <= FILL0;
        endcase
      end
    end
  end

`ifdef GL_PA_STRIP_WINDING_EN
  assign swap = (mode_q == PA_STRIP) && parity;
`else
  assign swap = 1'b0;
`endif

  assign out_v0 = swap ? s_v1 : s_v0;
  assign out_v1 = swap ? s_v0 : s_v1;
  assign out_v2 = s_v2;
  assign out_c0 = swap ? s_c1 : s_c0;
  assign out_c1 = swap ? s_c0 : s_c1;
  assign out_c2 = s_c2;

endmodule

// File: tb/tb_gl_prim_assembler.sv
// ----------------------------------------------------------------------------
// tb_gl_prim_assembler
// Directed bench for gl_prim_assembler: a queue-based FWFT FIFO model feeds
// the assembler; accepted triangles are collected and compared to hand-built
// expected vertex/color triples.
// ----------------------------------------------------------------------------
module tb_gl_prim_assembler;

  localparam int VW = 96;
  localparam int CW = 96;
  localparam int NW = 16;

  logic          clk;
  logic          reset;
  logic [1:0]    mode;
  logic          in_empty;
  logic [VW-1:0] in_vertex;
  logic [CW-1:0] in_color;
  logic          in_rd_en;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_v0, out_v1, out_v2;
  logic [CW-1:0] out_c0, out_c1, out_c2;
  logic          flush_out;
  logic          busy;
  logic [NW-1:0] tri_count;

  gl_prim_assembler #(.VTX_W(VW), .COL_W(CW), .CNT_W(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_empty  (in_empty),
    .in_vertex (in_vertex),
    .in_color  (in_color),
    .in_rd_en  (in_rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_v0    (out_v0),
    .out_v1    (out_v1),
    .out_v2    (out_v2),
    .out_c0    (out_c0),
    .out_c1    (out_c1),
    .out_c2    (out_c2),
    .flush_out (flush_out),
    .busy      (busy),
    .tri_count (tri_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int flush_cnt;

  logic [VW-1:0]     vq[$];
  logic [CW-1:0]     cq[$];
  logic [3*VW-1:0]   got_v[$];
  logic [3*CW-1:0]   got_c[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] vtx(input int id);
    logic [31:0] x;
    x = (id == 99) ? 32'hFFFF_FFFF : (32'h1000_0000 | 32'(id));
    return {x, 32'h2000_0000 | 32'(id), 32'h3000_0000 | 32'(id)};
  endfunction

  function automatic logic [CW-1:0] col(input int id);
    return {32'hC100_0000 | 32'(id), 32'hC200_0000 | 32'(id), 32'hC300_0000 | 32'(id)};
  endfunction

  task automatic refresh();
    in_empty  = (vq.size() == 0);
    in_vertex = in_empty ? '0 : vq[0];
    in_color  = in_empty ? '0 : cq[0];
  endtask

  task automatic push(input int id);
    vq.push_back(vtx(id));
    cq.push_back(col(id));
    refresh();
  endtask

  task automatic push_flush();
    vq.push_back({VW{1'b1}});
    cq.push_back('0);
    refresh();
  endtask

  // One clock: note pop/handshake before the edge, apply them after it.
  task automatic tick();
    logic pop, hs;
    pop = in_rd_en;
    hs  = out_valid && out_ready;
    if (hs) begin
      got_v.push_back({out_v0, out_v1, out_v2});
      got_c.push_back({out_c0, out_c1, out_c2});
    end
    @(posedge clk);
    #1;
    if (pop && vq.size() > 0) begin
      void'(vq.pop_front());
      void'(cq.pop_front());
    end
    if (flush_out) flush_cnt++;
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vq.delete();
    cq.delete();
    got_v.delete();
    got_c.delete();
    flush_cnt = 0;
    refresh();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_tri(input string tag, input int n, input int a, input int b, input int c);
    if (got_v.size() <= n) begin
      check({tag, "_present"}, 128'(got_v.size()), 128'(n + 1));
    end else begin
      check({tag, "_v0"}, 128'(got_v[n][3*VW-1:2*VW]), 128'(vtx(a)));
      check({tag, "_v1"}, 128'(got_v[n][2*VW-1:VW]),   128'(vtx(b)));
      check({tag, "_v2"}, 128'(got_v[n][VW-1:0]),      128'(vtx(c)));
      check({tag, "_c0"}, 128'(got_c[n][3*CW-1:2*CW]), 128'(col(a)));
      check({tag, "_c1"}, 128'(got_c[n][2*CW-1:CW]),   128'(col(b)));
      check({tag, "_c2"}, 128'(got_c[n][CW-1:0]),      128'(col(c)));
    end
  endtask

  initial begin
    reset     = 1'b0;
    mode      = 2'd0;
    out_ready = 1'b1;
    flush_cnt = 0;
    refresh();

    // Reset state, with a word waiting in the FIFO.
    push(1);
    @(posedge clk);
    #1;
    check("rst_rd_en",     128'(in_rd_en),  128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_flush_out", 128'(flush_out), 128'(0));
    check("rst_tri_count", 128'(tri_count), 128'(0));
    check("rst_out_v0",    128'(out_v0),    128'(0));

    // List mode; vertex 99 has all-ones x and must not act as a marker.
    do_reset();
    mode = 2'd0;
    push(1); push(2); push(99); push(4); push(5); push(6);
    run(16);
    check("list_ntri", 128'(got_v.size()), 128'(2));
    check_tri("list_t0", 0, 1, 2, 99);
    check_tri("list_t1", 1, 4, 5, 6);
    check("list_tri_count", 128'(tri_count), 128'(2));
    check("list_busy",      128'(busy),      128'(0));
    check("list_no_flush",  128'(flush_cnt), 128'(0));

    // Strip mode.
    do_reset();
    mode = 2'd1;
    push(1); push(2); push(3); push(4); push(5);
    run(16);
    check("strip_ntri", 128'(got_v.size()), 128'(3));
    check_tri("strip_t0", 0, 1, 2, 3);
`ifdef GL_PA_STRIP_WINDING_EN
    check_tri("strip_t1", 1, 3, 2, 4);
`else
    check_tri("strip_t1", 1, 2, 3, 4);
`endif
    check_tri("strip_t2", 2, 3, 4, 5);
    check("strip_tri_count", 128'(tri_count), 128'(3));

    // Fan mode; a mode change mid-stream must be ignored.
    do_reset();
    mode = 2'd2;
    push(1); push(2); push(3); push(4); push(5);
    run(3);
    mode = 2'd0;
    run(13);
    check("fan_ntri", 128'(got_v.size()), 128'(3));
    check_tri("fan_t0", 0, 1, 2, 3);
    check_tri("fan_t1", 1, 1, 3, 4);
    check_tri("fan_t2", 2, 1, 4, 5);

    // Flush discards a partial primitive.
    do_reset();
    mode = 2'd0;
    push(1); push(2); push_flush(); push(3); push(4); push(5);
    run(16);
    check("flush_pulses",    128'(flush_cnt),    128'(1));
    check("flush_ntri",      128'(got_v.size()), 128'(1));
    check_tri("flush_t0", 0, 3, 4, 5);
    check("flush_tri_count", 128'(tri_count),    128'(1));

    // Back-pressure: ten stalled cycles in EMIT with the FIFO non-empty.
    do_reset();
    mode      = 2'd3;
    out_ready = 1'b0;
    push(1); push(2); push(3); push(4);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("stall_valid", 128'(out_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_rd_en", 128'(in_rd_en),  128'(0));
      check("stall_v0",    128'(out_v0),    128'(vtx(1)));
      check("stall_v2",    128'(out_v2),    128'(vtx(3)));
      check("stall_valid_hold", 128'(out_valid), 128'(1));
    end
    check("stall_no_accept", 128'(got_v.size()), 128'(0));
    out_ready = 1'b1;
    tick();
    check("stall_ntri", 128'(got_v.size()), 128'(1));
    check_tri("stall_t0", 0, 1, 2, 3);
    check("stall_tri_count", 128'(tri_count), 128'(1));

    // Reset after two vertices: nothing emitted, counting restarts at 0.
    do_reset();
    mode = 2'd0;
    push(1); push(2);
    run(3);
    check("mid_busy", 128'(busy), 128'(1));
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy",  128'(busy),     128'(0));
    check("mid_rst_rd_en", 128'(in_rd_en), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(7); push(8); push(9);
    run(10);
    check("mid_ntri", 128'(got_v.size()), 128'(1));
    check_tri("mid_t0", 0, 7, 8, 9);
    check("mid_tri_count", 128'(tri_count), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
